// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings for the divider controller/datapath control bus
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    localparam logic [1:0] SEL_HOLD   = 2'b00;
    localparam logic [1:0] SEL_STEP   = 2'b01;
    localparam logic [1:0] SEL_IDLE   = 2'b10;
    localparam logic [1:0] SEL_FINISH = 2'b11;

endpackage

// File: rtl/div_addsub.sv
// rtl/div_addsub.sv - combinational two's-complement add/subtract, wrap-around
module div_addsub #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         add,
    output logic [W-1:0] y
);

    // Subtraction as a + ~b + 1 keeps a single adder for both operations.
    logic [W-1:0] b_op;

    assign b_op = add ? b : ~b;
    assign y    = a + b_op + {{(W-1){1'b0}}, ~add};

endmodule

// File: rtl/divider_datapath.sv
// rtl/divider_datapath.sv - sequential non-restoring divider datapath
module divider_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             load,
    input  logic             shift,
    input  logic             add,
    input  logic [1:0]       sel,
    input  logic             inbit,
    input  logic             valid,
    output logic             sign,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             div_zero
);

    localparam int RW = WIDTH + 2;

    logic [RW-1:0]    r_reg;
    logic [RW-1:0]    r_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] dividend_shadow;

    logic [RW-1:0]    r_shifted;
    logic [RW-1:0]    d_ext;
    logic [RW-1:0]    alu_a;
    logic             alu_add;
    logic [RW-1:0]    alu_y;
    logic             is_finish;

    assign sign      = r_reg[WIDTH+1];
    assign r_shifted = {r_reg[WIDTH:0], q_reg[WIDTH-1]};
    assign d_ext     = {2'b00, d_reg};
    assign is_finish = (sel == SEL_FINISH);

    // One adder serves both paths: finish only ever adds D back to correct R.
    assign alu_a   = is_finish ? r_reg : (shift ? r_shifted : r_reg);
    assign alu_add = is_finish ? 1'b1 : add;

    div_addsub #(
        .W (RW)
    ) u_addsub (
        .a   (alu_a),
        .b   (d_ext),
        .add (alu_add),
        .y   (alu_y)
    );

    always_comb begin
        r_next = r_reg;
        q_next = q_reg;
        if (is_finish) begin
            q_next = {q_reg[WIDTH-2:0], ~sign};
            if (sign) begin
                r_next = alu_y;
            end
        end else if (sel == SEL_STEP) begin
            r_next = alu_y;
            if (shift) begin
                q_next = {q_reg[WIDTH-2:0], inbit};
            end
        end else if (shift) begin
            r_next = r_shifted;
            q_next = {q_reg[WIDTH-2:0], inbit};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg           <= '0;
            q_reg           <= '0;
            d_reg           <= '0;
            dividend_shadow <= '0;
            div_zero        <= 1'b0;
        end else if (load) begin
            r_reg           <= '0;
            q_reg           <= dividend;
            d_reg           <= divisor;
            dividend_shadow <= dividend;
            div_zero        <= (divisor == '0);
        end else begin
            r_reg <= r_next;
            q_reg <= q_next;
        end
    end

    // Capture reads the pre-edge working registers, so a coincident load is harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
        end else begin
            done <= valid;
            if (valid) begin
                quotient  <= div_zero ? '1 : q_reg;
                remainder <= div_zero ? dividend_shadow : r_reg[WIDTH-1:0];
            end
        end
    end

endmodule

// File: doc/divider_datapath.md
Name: divider_datapath

Overview:
Sequential non-restoring divider datapath. It is the slave end of the divider controller's control bus: it executes load, shift, add, sel and inbit each cycle, and returns the sign of the partial remainder to the controller. When the controller raises valid, the block captures quotient and remainder into registered outputs and pulses done. One WIDTH-bit unsigned divide takes WIDTH iteration cycles plus one finish cycle.

Parameters:
WIDTH, 8, operand width in bits (dividend, divisor, quotient, remainder); legal range 4..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
dividend  input  WIDTH  unsigned dividend, sampled when load=1.
divisor  input  WIDTH  unsigned divisor, sampled when load=1.
load  input  1  initialise the working registers.
shift  input  1  shift {R,Q} left by one bit, inserting inbit at Q[0].
add  input  1  ALU op select: 1 = R+D, 0 = R-D.
sel  input  2  operation: 00 hold; 01 step (ALU); 10 hold; 11 finish.
inbit  input  1  quotient bit inserted at Q[0] on shift.
valid  input  1  controller result-ready strobe.
sign  output  1  R[WIDTH+1], the partial-remainder sign (combinational from the register).
quotient  output  WIDTH  registered quotient.
remainder  output  WIDTH  registered remainder.
done  output  1  one-cycle pulse, the cycle after valid is sampled.
div_zero  output  1  divisor was 0 at the last load; sticky until the next load.

Behaviour:
- Internal registers: R (WIDTH+2 bits, signed remainder), Q (WIDTH bits), D (WIDTH bits).
- Reset (reset=0, asynchronous): R, Q, D, quotient, remainder, done and div_zero all go to 0. Reset mid-operation abandons the divide, with no residual state.
- Priority per cycle: load > sel=11 > shift/sel=01 > hold.
- load=1: R<=0, Q<=dividend, D<=divisor, div_zero<=(divisor==0). All other controls are ignored that cycle. A load during a divide in progress restarts it.
- sel=01, shift=1: Rs={R[WIDTH:0],Q[WIDTH-1]}. R<=add ? Rs+D : Rs-D, with D zero-extended to WIDTH+2 bits. Q<={Q[WIDTH-2:0],inbit}.
- sel=01, shift=0: R<=R±D per add; Q unchanged.
- sel=00/10, shift=1: shift only, with R<=Rs and Q shifted as above; no ALU operation.
- sel=00/10, shift=0: hold.
- sel=11 (finish): Q<={Q[WIDTH-2:0],~sign}. R<=sign ? R+D : R (remainder correction). shift and add are ignored.
- Arithmetic is two's complement, WIDTH+2 bits, wrap-around; no saturation.
- Controller contract (not enforced here):
  - WIDTH cycles of shift=1, sel=01, add=sign, inbit=~sign. The first inbit is a dummy and is shifted out.
  - Then one cycle of sel=11.
  - Then valid=1.
- valid sampled 1: next edge quotient<=div_zero ? all-ones : Q, remainder<=div_zero ? dividend-as-loaded (kept in a shadow register) : R[WIDTH-1:0], done<=1. done clears the following cycle unless valid is held.
- valid and load in the same cycle: the capture uses pre-load Q/R; the load proceeds.
- sign reflects R after every edge, including 0 after reset and after load.

Decomposition:
- Shared package div_pkg: sel encodings SEL_HOLD=2'b00, SEL_STEP=2'b01, SEL_IDLE=2'b10, SEL_FINISH=2'b11, and DIV_WIDTH_DEFAULT=8. The controller imports the same package.
- One natural sub-module, div_addsub: a combinational WIDTH+2-bit add/subtract, instantiated once for both the step and finish ALU paths.

Test Plan:
- Reset: assert reset=0 mid-divide → sign=0, quotient=0, remainder=0, done=0, div_zero=0 immediately, without waiting for a clock edge.
- Single step: load 13/3, then shift=1, sel=01, add=0, inbit=0 → R=-3 (all ones except low bits 101), sign=1, Q=8'h1A.
- Full divide (behavioural controller model): 100/7 → quotient=14, remainder=2, done high exactly one cycle after valid.
- Corner operands with WIDTH=8:
  - 255/1 → 255 r 0
  - 0/5 → 0 r 0
  - 7/200 → 0 r 7
  - 255/255 → 1 r 0
- Divide by zero: load 9/0 → div_zero=1; after the full sequence and valid → quotient=8'hFF, remainder=9.
- Restart: load 50/4, then after 3 steps load 50/6 and run the full sequence → quotient=8, remainder=2. Simultaneous valid+load captures the old Q/R.
